// File: rtl/xpb_reduce_seq.sv
// -----------------------------------------------------------------------------
// xpb_reduce_seq
//
// Sequential xpb reduction accumulator. An accepted operation carries
// NUM_DIGITS packed digits. The block walks them one per cycle, addressing
// table idx with digit[idx] on lut_sel/lut_digit. It adds the combinational
// table response lut_data into a widened accumulator. When the last digit has
// been added, it presents the sum with a valid/ready handshake.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous abort, returns to IDLE and clears acc/idx
//   in_valid   : in_digits valid
//   in_ready   : high only in IDLE
//   in_digits  : NUM_DIGITS x DIGIT_W packed digits, digit i at [i*DIGIT_W +: DIGIT_W]
//   lut_sel    : table index being addressed (0 outside RUN)
//   lut_digit  : digit presented to the addressed table (0 outside RUN)
//   lut_data   : table response for lut_sel/lut_digit, same cycle
//   out_valid  : high in DONE
//   out_ready  : consumer accepts out_sum
//   out_sum    : accumulator register, meaningful only while out_valid=1
//   busy       : high in RUN or DONE
// -----------------------------------------------------------------------------
module xpb_reduce_seq #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 5,
    parameter int DATA_W     = 1024,
    localparam int SEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int ACC_W     = DATA_W + $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_digits,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [DIGIT_W-1:0]            lut_digit,
    input  logic [DATA_W-1:0]             lut_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic                          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

    logic [1:0]                    state_q, state_d;
    logic [SEL_W-1:0]              idx_q, idx_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
    logic [DIGIT_W-1:0]            cur_digit;
    logic                          run;

    assign run = (state_q == S_RUN);

    // Digit selected by the registered index; explicit mux so that an idx
    // value beyond NUM_DIGITS-1 (non power-of-two counts) reads as zero.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == SEL_W'(i)) begin
                cur_digit = digits_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        digits_d = digits_q;
        if (flush) begin
            // Abort wins over accept and over the output handshake.
            state_d = S_IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        digits_d = in_digits;
                        idx_d    = '0;
                        acc_d    = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    // Every digit costs one cycle, zero or not, so latency is fixed.
                    acc_d = acc_q + ACC_W'(lut_data);
                    idx_d = idx_q + SEL_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            digits_q <= digits_d;
        end
    end

    // Table address comes purely from registers, so lut_data has no
    // combinational loop back through lut_sel/lut_digit.
    assign lut_sel   = run ? idx_q : '0;
    assign lut_digit = run ? cur_digit : '0;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_sum   = acc_q;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
module tb_xpb_reduce_seq;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 5;
    localparam int DATA_W     = 1024;
    localparam int SEL_W      = 3;
    localparam int ACC_W      = 1027;
    localparam int IN_W       = NUM_DIGITS * DIGIT_W;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_digits;
    logic [SEL_W-1:0]  lut_sel;
    logic [DIGIT_W-1:0] lut_digit;
    logic [DATA_W-1:0] lut_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              busy;

    int mode;
    int errors;
    int checks;
    logic [ACC_W-1:0] sb_q[$];

    xpb_reduce_seq #(
        .NUM_DIGITS(NUM_DIGITS),
        .DIGIT_W   (DIGIT_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_digits(in_digits),
        .lut_sel  (lut_sel),
        .lut_digit(lut_digit),
        .lut_data (lut_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub table: 0 = always zero, 1 = all-ones for nonzero digit,
    // 2 = lut_sel*32 + lut_digit.
    always_comb begin
        lut_data = '0;
        case (mode)
            1: lut_data = (lut_digit != '0) ? '1 : '0;
            2: lut_data[7:0] = {lut_sel, lut_digit};
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h (low 64b) required %0h (low 64b) upper_equal=%0b",
                     name, act[63:0], exp[63:0], act[ACC_W-1:64] === exp[ACC_W-1:64]);
        end
    endtask

    // Scoreboard monitor: a handshake completes at the next rising edge
    // whenever out_valid && out_ready && !flush at the preceding falling edge.
    initial begin
        logic [ACC_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result %0h (low 64b) required no result", out_sum[63:0]);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_sum", out_sum, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count falling edges after the accept edge until out_valid, checking the
    // table address sequence along the way; bounded at 20 cycles.
    task automatic wait_out(input logic [IN_W-1:0] dg, output int cyc);
        logic [DIGIT_W-1:0] d;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid || cyc >= 20) break;
            if (cyc <= NUM_DIGITS) begin
                d = dg[(cyc-1)*DIGIT_W +: DIGIT_W];
                chk("lut_sel", ACC_W'(lut_sel), ACC_W'(cyc - 1));
                chk("lut_digit", ACC_W'(lut_digit), ACC_W'(d));
            end
        end
    endtask

    task automatic run_op(input logic [IN_W-1:0] dg, input int m, input logic [ACC_W-1:0] exp);
        int cyc;
        mode      = m;
        in_digits = dg;
        sb_q.push_back(exp);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        wait_out(dg, cyc);
        chk("latency", ACC_W'(cyc), ACC_W'(9));
        tick();
        chk("in_ready_after_hs", ACC_W'(in_ready), ACC_W'(1));
    endtask

    logic [IN_W-1:0]  dg_seq;
    logic [IN_W-1:0]  dg_full;
    logic [IN_W-1:0]  dg_mix;
    logic [ACC_W-1:0] exp_full;
    logic [ACC_W-1:0] exp_mix;

    initial begin
        int cyc;
        errors    = 0;
        checks    = 0;
        mode      = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_digits = '0;

        dg_seq   = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        dg_full  = {8{5'h1F}};
        dg_mix   = {5'd0, 5'h1F, 5'd0, 5'd3, 5'd0, 5'd0, 5'd7, 5'd0};
        exp_full = '1;
        exp_full[2:0] = 3'b000;                 // 8*(2^1024-1) = 2^1027-8
        exp_mix  = (ACC_W'(3) << DATA_W) - ACC_W'(3); // three nonzero digits

        // Reset values while rst_n is low
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
        chk("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("rst_busy", ACC_W'(busy), ACC_W'(0));
        chk("rst_lut_sel", ACC_W'(lut_sel), ACC_W'(0));
        chk("rst_lut_digit", ACC_W'(lut_digit), ACC_W'(0));
        chk("rst_out_sum", out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero table and digits; then sequential, full-scale, mixed
        run_op('0, 0, '0);
        run_op(dg_seq, 2, ACC_W'(932));
        run_op(dg_full, 1, exp_full);
        run_op(dg_mix, 1, exp_mix);
        run_op('0, 2, ACC_W'(896));            // zero digits still visited
        run_op(dg_full, 2, ACC_W'(1144));

        // Backpressure in DONE, with in_valid presented meanwhile
        out_ready = 1'b0;
        mode      = 2;
        in_digits = dg_seq;
        sb_q.push_back(ACC_W'(932));
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        wait_out(dg_seq, cyc);
        chk("bp_latency", ACC_W'(cyc), ACC_W'(9));
        in_digits = dg_full;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", ACC_W'(out_valid), ACC_W'(1));
            chk("bp_in_ready", ACC_W'(in_ready), ACC_W'(0));
            chk("bp_out_sum", out_sum, ACC_W'(932));
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", ACC_W'(in_ready), ACC_W'(1));
        chk("bp_busy_after", ACC_W'(busy), ACC_W'(0));

        // Flush during RUN at idx=3
        mode      = 2;
        in_digits = dg_seq;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("fl_idx3", ACC_W'(lut_sel), ACC_W'(3));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_in_ready", ACC_W'(in_ready), ACC_W'(1));
        chk("fl_busy", ACC_W'(busy), ACC_W'(0));
        chk("fl_out_sum_clr", out_sum, '0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("fl_no_out_valid", ACC_W'(seen), ACC_W'(0));
        end

        // Flush together with in_valid in IDLE: no accept
        tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_idle_in_ready", ACC_W'(in_ready), ACC_W'(1));
        chk("fl_idle_busy", ACC_W'(busy), ACC_W'(0));
        run_op(dg_seq, 2, ACC_W'(932));

        // Flush with out_ready in DONE: result discarded
        out_ready = 1'b0;
        in_digits = dg_full;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        wait_out(dg_full, cyc);
        chk("fd_latency", ACC_W'(cyc), ACC_W'(9));
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        @(negedge clk);
        chk("fd_out_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("fd_in_ready", ACC_W'(in_ready), ACC_W'(1));

        // Asynchronous reset mid-RUN, between edges
        tick();
        mode      = 2;
        in_digits = dg_seq;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_in_ready", ACC_W'(in_ready), ACC_W'(1));
        chk("ar_out_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("ar_busy", ACC_W'(busy), ACC_W'(0));
        chk("ar_lut_sel", ACC_W'(lut_sel), ACC_W'(0));
        chk("ar_lut_digit", ACC_W'(lut_digit), ACC_W'(0));
        chk("ar_out_sum", out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(dg_seq, 2, ACC_W'(932));

        repeat (4) tick();
        chk("sb_drained", ACC_W'(sb_q.size()), ACC_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
